// File: rtl/mult_arbiter_16_pkg.sv
// Shared widths, pipeline entry records and Dadda stage heights for the
// two-requester multiplier arbiter.
package mult_arbiter_16_pkg;

  localparam int unsigned PROD_W  = 32;
  localparam int unsigned OP_W    = 16;
  localparam int unsigned NUM_REQ = 2;

  localparam int unsigned DADDA_STAGES = 6;

  typedef struct packed {
    logic            valid;
    logic            id;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } s1_entry_t;

  typedef struct packed {
    logic              valid;
    logic              id;
    logic [PROD_W-1:0] prod;
  } s2_entry_t;

  // Target column height after each reduction stage (16 partial products).
  function automatic int unsigned dadda_height(input int unsigned stage);
    case (stage)
      0:       return 13;
      1:       return 9;
      2:       return 6;
      3:       return 4;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/dadda_mult_16.sv
// Combinational 16x16 unsigned Dadda multiplier; 31-bit final adder with its
// carry-out folded into bit 31 of the product.
module dadda_mult_16
  import mult_arbiter_16_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  localparam int unsigned CIW = $clog2(PROD_W);

  always_comb begin
    logic [OP_W-1:0]   cur  [PROD_W];
    logic [OP_W-1:0]   nxt  [PROD_W];
    int unsigned       ccnt [PROD_W];
    int unsigned       ncnt [PROD_W];
    logic [OP_W-1:0]   w, ai, bj;
    logic              s_bit, c_bit;
    int unsigned       k, d, tot, col;
    logic [PROD_W-1:0] x, y, lo;

    for (int unsigned c = 0; c < PROD_W; c++) begin
      cur[CIW'(c)]  = '0;
      nxt[CIW'(c)]  = '0;
      ccnt[CIW'(c)] = 0;
      ncnt[CIW'(c)] = 0;
    end
    w = '0; ai = '0; bj = '0;
    s_bit = 1'b0; c_bit = 1'b0;
    k = 0; d = 0; tot = 0; col = 0;
    x = '0; y = '0; lo = '0;

    for (int unsigned i = 0; i < OP_W; i++) begin
      for (int unsigned j = 0; j < OP_W; j++) begin
        ai  = a >> i;
        bj  = b >> j;
        col = i + j;
        cur[CIW'(col)]  = cur[CIW'(col)] | (OP_W'(ai[0] & bj[0]) << ccnt[CIW'(col)]);
        ccnt[CIW'(col)] = ccnt[CIW'(col)] + 1;
      end
    end

    // Columns are bit stacks consumed from the LSB; carries land in the next
    // column of the new stage before that column is processed.
    for (int unsigned s = 0; s < DADDA_STAGES; s++) begin
      d = dadda_height(s);
      for (int unsigned c = 0; c < PROD_W; c++) begin
        nxt[CIW'(c)]  = '0;
        ncnt[CIW'(c)] = 0;
      end
      for (int unsigned c = 0; c < PROD_W; c++) begin
        k = 0;
        for (int unsigned r = 0; r < OP_W; r++) begin
          tot = ccnt[CIW'(c)] - k + ncnt[CIW'(c)];
          if (tot > d && ccnt[CIW'(c)] - k >= 2) begin
            w = cur[CIW'(c)] >> k;
            if (tot - d >= 2 && ccnt[CIW'(c)] - k >= 3) begin
              s_bit = w[0] ^ w[1] ^ w[2];
              c_bit = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
              k     = k + 3;
            end else begin
              s_bit = w[0] ^ w[1];
              c_bit = w[0] & w[1];
              k     = k + 2;
            end
            nxt[CIW'(c)]  = nxt[CIW'(c)] | (OP_W'(s_bit) << ncnt[CIW'(c)]);
            ncnt[CIW'(c)] = ncnt[CIW'(c)] + 1;
            if (c + 1 < PROD_W) begin
              nxt[CIW'(c + 1)]  = nxt[CIW'(c + 1)] | (OP_W'(c_bit) << ncnt[CIW'(c + 1)]);
              ncnt[CIW'(c + 1)] = ncnt[CIW'(c + 1)] + 1;
            end
          end
        end
        for (int unsigned r = 0; r < OP_W; r++) begin
          if (k + r < ccnt[CIW'(c)]) begin
            w = cur[CIW'(c)] >> (k + r);
            nxt[CIW'(c)]  = nxt[CIW'(c)] | (OP_W'(w[0]) << ncnt[CIW'(c)]);
            ncnt[CIW'(c)] = ncnt[CIW'(c)] + 1;
          end
        end
      end
      cur  = nxt;
      ccnt = ncnt;
    end

    for (int unsigned c = 0; c < PROD_W; c++) begin
      w = cur[CIW'(c)];
      x[CIW'(c)] = w[0];
      y[CIW'(c)] = w[1];
    end
    lo   = {1'b0, x[PROD_W-2:0]} + {1'b0, y[PROD_W-2:0]};
    prod = {lo[PROD_W-1] ^ x[PROD_W-1] ^ y[PROD_W-1], lo[PROD_W-2:0]};
  end

endmodule

// File: rtl/mult_arbiter_16.sv
// Round-robin arbiter sharing one Dadda multiplier between two requesters
// through a two-stage valid/ready pipeline.
module mult_arbiter_16
  import mult_arbiter_16_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [OP_W-1:0]    req_a0,
  input  logic [OP_W-1:0]    req_b0,
  input  logic [OP_W-1:0]    req_a1,
  input  logic [OP_W-1:0]    req_b1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [PROD_W-1:0]  rsp_prod,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt
);

  s1_entry_t           s1;
  s2_entry_t           s2;
  logic                ptr;
  logic                s1_adv, s2_adv;
  logic [NUM_REQ-1:0]  grant, acc;
  logic [PROD_W-1:0]   mult_prod;

  dadda_mult_16 u_mult (
    .a    (s1.a),
    .b    (s1.b),
    .prod (mult_prod)
  );

  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign s2_adv    = !s2.valid || rsp_ready;
  assign s1_adv    = !s1.valid || s2_adv;
  // rst_n gating keeps req_ready low for the whole reset window.
  assign req_ready = grant & {NUM_REQ{s1_adv & rst_n}};
  assign acc       = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      ptr      <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (|acc) ptr <= ~acc[1];
      if (s1_adv) begin
        s1.valid <= |acc;
        if (|acc) begin
          s1.id <= acc[1];
          s1.a  <= acc[1] ? req_a1 : req_a0;
          s1.b  <= acc[1] ? req_b1 : req_b0;
        end
      end
      if (s2_adv) begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.id   <= s1.id;
          s2.prod <= mult_prod;
        end
      end
      if (s2.valid && rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign rsp_valid = s2.valid;
  assign rsp_id    = s2.id;
  assign rsp_prod  = s2.prod;
  assign busy      = s1.valid | s2.valid;

endmodule

// File: tb/tb_mult_arbiter_16.sv
// Scoreboard bench for mult_arbiter_16: accepts push expected products,
// response transfers pop and compare.
module tb_mult_arbiter_16;
  import mult_arbiter_16_pkg::*;

  localparam int unsigned CW = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [OP_W-1:0]    req_a0, req_b0, req_a1, req_b1;
  logic               rsp_valid, rsp_ready, rsp_id, busy;
  logic [PROD_W-1:0]  rsp_prod;
  logic [CW-1:0]      done_cnt;

  mult_arbiter_16 #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              id;
    logic [PROD_W-1:0] prod;
  } exp_t;

  exp_t          sb [$];
  int unsigned   checks = 0;
  int unsigned   passed = 0;
  logic [CW-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        exp_cnt = exp_cnt + 1'b1;
        if (sb.size() == 0) begin
          $display("FAIL rsp_unexpected: got id=%0d prod=0x%08h, required no response", rsp_id, rsp_prod);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_prod !== e.prod)
            $display("FAIL rsp_data: got id=%0d prod=0x%08h, required id=%0d prod=0x%08h",
                     rsp_id, rsp_prod, e.id, e.prod);
          else passed++;
        end
      end
      if (req_valid[0] && req_ready[0])
        sb.push_back('{id: 1'b0, prod: PROD_W'(req_a0) * PROD_W'(req_b0)});
      if (req_valid[1] && req_ready[1])
        sb.push_back('{id: 1'b1, prod: PROD_W'(req_a1) * PROD_W'(req_b1)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic send(input int unsigned id, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                      output logic ok);
    logic [NUM_REQ-1:0] sel;
    sel = NUM_REQ'(1) << id;
    ok  = 1'b0;
    if (id == 0) begin req_a0 = a; req_b0 = b; end
    else         begin req_a1 = a; req_b1 = b; end
    req_valid = sel;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if ((req_ready & sel) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset();
    logic ok;
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 2'b11;
    req_a0 = '0; req_b0 = '0; req_a1 = 16'd1; req_b1 = 16'd1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b, required 00", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
    checks++; if (done_cnt !== '0) $display("FAIL reset_done_cnt: got %0d, required 0", done_cnt); else passed++;
    checks++; if (rsp_prod !== '0) $display("FAIL reset_rsp_prod: got 0x%08h, required 0", rsp_prod); else passed++;
    checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b, required 0", rsp_id); else passed++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL reset_first_grant: got %b, required 01", req_ready); else passed++;
    tick();
    req_valid = '0;
    drain(ok);
    checks++; if (!ok) $display("FAIL reset_drain: got timeout, required empty pipeline"); else passed++;
    checks++; if (done_cnt !== CW'(1)) $display("FAIL reset_zero_cnt: got %0d, required 1", done_cnt); else passed++;
  endtask

  task automatic test_single();
    logic ok;
    apply_reset();
    rsp_ready = 1'b1;
    req_a0 = 16'd3; req_b0 = 16'd5; req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL single_accept: got %b, required 01", req_ready); else passed++;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL single_early: got rsp_valid=%b, required 0", rsp_valid); else passed++;
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_latency: got rsp_valid=%b, required 1", rsp_valid); else passed++;
    checks++; if (rsp_prod !== 32'd15 || rsp_id !== 1'b0)
      $display("FAIL single_result: got id=%0d prod=%0d, required id=0 prod=15", rsp_id, rsp_prod); else passed++;
    tick();
    drain(ok);
    checks++; if (!ok) $display("FAIL single_drain: got timeout, required empty pipeline"); else passed++;
    checks++; if (done_cnt !== CW'(1)) $display("FAIL single_done_cnt: got %0d, required 1", done_cnt); else passed++;
  endtask

  task automatic test_contention();
    logic ok;
    logic [NUM_REQ-1:0] want;
    apply_reset();
    rsp_ready = 1'b1;
    req_a0 = 16'd2; req_b0 = 16'd7; req_a1 = 16'd4; req_b1 = 16'd9;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (req_ready !== want) $display("FAIL contention_grant%0d: got %b, required %b", i, req_ready, want); else passed++;
      tick();
    end
    req_valid = '0;
    drain(ok);
    checks++; if (!ok) $display("FAIL contention_drain: got timeout, required empty pipeline"); else passed++;
    checks++; if (done_cnt !== CW'(4)) $display("FAIL contention_done_cnt: got %0d, required 4", done_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    logic ok, took;
    int unsigned acc_n;
    logic [NUM_REQ-1:0] want;
    apply_reset();
    rsp_ready = 1'b0;
    acc_n = 0;
    req_a0 = 16'd10; req_b0 = 16'd3; req_valid = 2'b01;
    for (int cyc = 0; cyc < 7; cyc++) begin
      want = (cyc < 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      took = req_ready[0];
      checks++; if (req_ready !== want) $display("FAIL bp_ready%0d: got %b, required %b", cyc, req_ready, want); else passed++;
      if (cyc >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_prod !== 32'd30 || rsp_id !== 1'b0)
          $display("FAIL bp_hold%0d: got valid=%b id=%0d prod=%0d, required valid=1 id=0 prod=30", cyc, rsp_valid, rsp_id, rsp_prod);
        else passed++;
      end
      if (took) acc_n++;
      tick();
      if (took) req_a0 = req_a0 + 16'd1;
    end
    checks++; if (acc_n != 2) $display("FAIL bp_accepts: got %0d, required 2", acc_n); else passed++;
    rsp_ready = 1'b1;
    for (int n = 0; n < 20 && acc_n < 4; n++) begin
      @(negedge clk);
      took = req_ready[0];
      tick();
      if (took) begin
        acc_n++;
        req_a0 = req_a0 + 16'd1;
      end
    end
    req_valid = '0;
    drain(ok);
    checks++; if (!ok) $display("FAIL bp_drain: got timeout, required empty pipeline"); else passed++;
    checks++; if (done_cnt !== CW'(4)) $display("FAIL bp_done_cnt: got %0d, required 4", done_cnt); else passed++;
  endtask

  task automatic test_corners();
    logic ok, all_ok;
    rsp_ready = 1'b1;
    all_ok = 1'b1;
    send(0, 16'hFFFF, 16'hFFFF, ok); all_ok &= ok;
    send(1, 16'h8000, 16'h0002, ok); all_ok &= ok;
    send(0, 16'h0000, 16'hABCD, ok); all_ok &= ok;
    send(1, 16'hFFFF, 16'h0001, ok); all_ok &= ok;
    send(0, 16'h1234, 16'h5678, ok); all_ok &= ok;
    checks++; if (!all_ok) $display("FAIL corners_accept: got timeout, required accept"); else passed++;
    drain(ok);
    checks++; if (!ok) $display("FAIL corners_drain: got timeout, required empty pipeline"); else passed++;
    checks++; if (done_cnt !== exp_cnt) $display("FAIL corners_done_cnt: got %0d, required %0d", done_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic ok, seen;
    rsp_ready = 1'b0;
    req_a0 = 16'd6; req_b0 = 16'd7; req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL mid_accept0: got %b, required 01", req_ready); else passed++;
    tick();
    req_a0 = 16'd8; req_b0 = 16'd9;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL mid_accept1: got %b, required 01", req_ready); else passed++;
    tick();
    rst_n = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || busy !== 1'b0)
      $display("FAIL mid_in_reset: got ready=%b busy=%b, required ready=00 busy=0", req_ready, busy); else passed++;
    tick();
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) $display("FAIL mid_ghost_rsp: got rsp_valid=1, required 0"); else passed++;
    checks++; if (done_cnt !== '0) $display("FAIL mid_done_cnt: got %0d, required 0", done_cnt); else passed++;
    req_a0 = 16'd1; req_b0 = 16'd2; req_a1 = 16'd3; req_b1 = 16'd4; req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL mid_pointer: got %b, required 01", req_ready); else passed++;
    tick();
    req_valid = '0;
    drain(ok);
    checks++; if (!ok) $display("FAIL mid_drain: got timeout, required empty pipeline"); else passed++;
  endtask

  task automatic test_wrap();
    logic ok, all_ok;
    apply_reset();
    rsp_ready = 1'b1;
    all_ok = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send(k % 2, 16'(k), 16'(k + 3), ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) $display("FAIL wrap_accept: got timeout, required accept"); else passed++;
    drain(ok);
    checks++; if (!ok) $display("FAIL wrap_drain: got timeout, required empty pipeline"); else passed++;
    checks++; if (done_cnt !== CW'(1)) $display("FAIL wrap_done_cnt: got %0d, required 1", done_cnt); else passed++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_corners();
    test_reset_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
